rsa_exp_ctrl: RTL and testbench

//  Sequencer for RSA modular exponentiation m = y^e mod n (right-to-left square-and-multiply).

---
 rtl/rsa_pkg.sv | 22 ++
 rtl/rsa_exp_ctrl.sv | 144 ++++++++++++++
 tb/tb_rsa_exp_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA modular-exponentiation sequencer.
// Optional build macro used by the sequencer: RSA_EARLY_EXIT_EN.
package rsa_pkg;

  localparam int RSA_NBITS = 256;
  localparam int RSA_CNT_W = 8;

  typedef logic [RSA_NBITS-1:0] operand_t;

  typedef enum logic [3:0] {
    IDLE,
    PREP_REQ,
    PREP_WAIT,
    BIT,
    MUL_REQ,
    MUL_WAIT,
    SQR_REQ,
    SQR_WAIT,
    FIN
  } state_t;

endpackage

// File: rtl/rsa_exp_ctrl.sv
// Right-to-left square-and-multiply sequencer for m = y^e mod n.
// Drives a precompute unit (t = y*2^NBITS mod n) and one shared Montgomery
// multiplier through start/done handshakes. m stays in the normal domain
// (starts at 1), t stays in the Montgomery domain, so mont(m,t) = m*y^(2^i).
// Build option: define RSA_EARLY_EXIT_EN to finish as soon as the remaining
// exponent bits are all zero; without it every run takes NBITS iterations.
module rsa_exp_ctrl
  import rsa_pkg::*;
#(
  parameter int NBITS = RSA_NBITS,
  parameter int CNT_W = RSA_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NBITS-1:0] n,
  input  logic [NBITS-1:0] e,
  input  logic [NBITS-1:0] y,
  output logic [NBITS-1:0] m,
  output logic             done,
  output logic             busy,
  output logic             prep_start,
  output logic [NBITS-1:0] prep_a1,
  output logic [NBITS-1:0] prep_a3,
  input  logic [NBITS-1:0] prep_result,
  input  logic             prep_done,
  output logic             mont_start,
  output logic [NBITS-1:0] mont_a,
  output logic [NBITS-1:0] mont_b,
  output logic [NBITS-1:0] mont_n,
  input  logic [NBITS-1:0] mont_result,
  input  logic             mont_done
);

  state_t           state;
  state_t           state_nx;
  logic [NBITS-1:0] n_q;
  logic [NBITS-1:0] y_q;
  logic [NBITS-1:0] e_sh;
  logic [NBITS-1:0] t_q;
  logic [NBITS-1:0] m_q;
  logic [CNT_W-1:0] idx;
  logic             last_bit;

  // Terminal compare on the bit index itself so the counter never relies on overflow.
  assign last_bit = (idx == CNT_W'(NBITS - 1));

  assign m       = m_q;
  assign prep_a1 = y_q;
  assign prep_a3 = n_q;
  assign mont_n  = n_q;
  assign mont_b  = t_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state decode and handshake strobes; only REQ states pulse a start.
  always_comb begin
    state_nx   = state;
    prep_start = 1'b0;
    mont_start = 1'b0;
    done       = 1'b0;
    busy       = (state != IDLE);
    mont_a     = t_q;
    case (state)
      IDLE:      if (start) state_nx = PREP_REQ;
      PREP_REQ: begin
        prep_start = 1'b1;
        state_nx   = PREP_WAIT;
      end
      PREP_WAIT: if (prep_done) state_nx = BIT;
      BIT: begin
        if (e_sh[0]) state_nx = MUL_REQ;
        else         state_nx = SQR_REQ;
`ifdef RSA_EARLY_EXIT_EN
        if (e_sh == '0) state_nx = FIN;
`endif
      end
      MUL_REQ: begin
        mont_start = 1'b1;
        mont_a     = m_q;
        state_nx   = MUL_WAIT;
      end
      MUL_WAIT: begin
        mont_a = m_q;
        if (mont_done) state_nx = SQR_REQ;
      end
      SQR_REQ: begin
        mont_start = 1'b1;
        state_nx   = SQR_WAIT;
      end
      SQR_WAIT: begin
        if (mont_done) state_nx = last_bit ? FIN : BIT;
      end
      FIN: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default:   state_nx = IDLE;
    endcase
  end

  // Working registers: result, Montgomery-domain power, shifted exponent, bit index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q  <= '0;
      t_q  <= '0;
      e_sh <= '0;
      idx  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            m_q  <= NBITS'(1);
            e_sh <= e;
            idx  <= '0;
          end
        end
        PREP_WAIT: if (prep_done) t_q <= prep_result;
        MUL_WAIT:  if (mont_done) m_q <= mont_result;
        SQR_WAIT: begin
          if (mont_done) begin
            t_q  <= mont_result;
            e_sh <= e_sh >> 1;
            idx  <= idx + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Operand capture on an accepted start; plain data, no reset needed.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      n_q <= n;
      y_q <= y;
    end
  end

endmodule

// File: tb/tb_rsa_exp_ctrl.sv
// Bench for rsa_exp_ctrl: an 8-bit and a 256-bit instance, each with
// behavioural precompute/Montgomery responders of configurable latency.
`timescale 1ns/1ps
module tb_rsa_exp_ctrl;

`ifdef RSA_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;
  int lat_p  = 3;
  int lat_m  = 2;
  bit big    = 1'b0;

  // 8-bit instance signals
  logic [7:0] a_n = '0, a_e = '0, a_y = '0;
  logic       a_start = 1'b0;
  logic [7:0] a_m, a_prep_a1, a_prep_a3, a_mont_a, a_mont_b, a_mont_n;
  logic       a_done, a_busy, a_prep_start, a_mont_start;
  logic [7:0] a_prep_result = '0, a_mont_result = '0;
  logic       a_prep_done = 1'b0, a_mont_done = 1'b0;

  // 256-bit instance signals
  logic [255:0] b_n = '0, b_e = '0, b_y = '0;
  logic         b_start = 1'b0;
  logic [255:0] b_m, b_prep_a1, b_prep_a3, b_mont_a, b_mont_b, b_mont_n;
  logic         b_done, b_busy, b_prep_start, b_mont_start;
  logic [255:0] b_prep_result = '0, b_mont_result = '0;
  logic         b_prep_done = 1'b0, b_mont_done = 1'b0;

  rsa_exp_ctrl #(.NBITS(8), .CNT_W(3)) dut8 (
    .clk(clk), .rst(rst), .start(a_start), .n(a_n), .e(a_e), .y(a_y),
    .m(a_m), .done(a_done), .busy(a_busy),
    .prep_start(a_prep_start), .prep_a1(a_prep_a1), .prep_a3(a_prep_a3),
    .prep_result(a_prep_result), .prep_done(a_prep_done),
    .mont_start(a_mont_start), .mont_a(a_mont_a), .mont_b(a_mont_b),
    .mont_n(a_mont_n), .mont_result(a_mont_result), .mont_done(a_mont_done)
  );

  rsa_exp_ctrl #(.NBITS(256), .CNT_W(8)) dut256 (
    .clk(clk), .rst(rst), .start(b_start), .n(b_n), .e(b_e), .y(b_y),
    .m(b_m), .done(b_done), .busy(b_busy),
    .prep_start(b_prep_start), .prep_a1(b_prep_a1), .prep_a3(b_prep_a3),
    .prep_result(b_prep_result), .prep_done(b_prep_done),
    .mont_start(b_mont_start), .mont_a(b_mont_a), .mont_b(b_mont_b),
    .mont_n(b_mont_n), .mont_result(b_mont_result), .mont_done(b_mont_done)
  );

  // ---------------- arithmetic reference ----------------
  function automatic logic [255:0] mulmod(input logic [255:0] a, input logic [255:0] b,
                                          input logic [255:0] n);
    logic [519:0] p;
    p = (520'(a) * 520'(b)) % 520'(n);
    return p[255:0];
  endfunction

  function automatic logic [255:0] to_mont(input logic [255:0] a, input logic [255:0] n,
                                           input int nb);
    logic [519:0] p;
    p = (520'(a) << nb) % 520'(n);
    return p[255:0];
  endfunction

  function automatic logic [255:0] mont(input logic [255:0] a, input logic [255:0] b,
                                        input logic [255:0] n, input int nb);
    logic [519:0] t;
    t = 520'(a) * 520'(b);
    for (int i = 0; i < nb; i++) begin
      if (t[0]) t = t + 520'(n);
      t = t >> 1;
    end
    if (t >= 520'(n)) t = t - 520'(n);
    return t[255:0];
  endfunction

  function automatic logic [255:0] modexp(input logic [255:0] y, input logic [255:0] e,
                                          input logic [255:0] n, input int nb);
    logic [255:0] r, b;
    r = mulmod(256'd1, 256'd1, n);
    b = mulmod(y, 256'd1, n);
    for (int i = 0; i < nb; i++) begin
      if (e[i]) r = mulmod(r, b, n);
      b = mulmod(b, b, n);
    end
    return r;
  endfunction

  function automatic int bitlen(input logic [255:0] v);
    int r;
    r = 0;
    for (int i = 0; i < 256; i++) if (v[i]) r = i + 1;
    return r;
  endfunction

  function automatic int popcnt(input logic [255:0] v);
    int r;
    r = 0;
    for (int i = 0; i < 256; i++) if (v[i]) r++;
    return r;
  endfunction

  // ---------------- behavioural sub-units ----------------
  bit a_ppend = 1'b0, a_mpend = 1'b0, b_ppend = 1'b0, b_mpend = 1'b0;
  int a_pcnt = 0, a_mcnt = 0, b_pcnt = 0, b_mcnt = 0;
  int a_ovl = 0, b_ovl = 0, a_dcnt = 0, b_dcnt = 0;
  logic [511:0] a_log[$];
  logic [511:0] b_log[$];

  always @(posedge clk) begin
    logic [255:0] tmp;
    a_prep_done <= 1'b0;
    a_mont_done <= 1'b0;
    if (a_done) a_dcnt <= a_dcnt + 1;
    if (a_ppend) begin
      if (a_pcnt <= 1) begin a_ppend <= 1'b0; a_prep_done <= 1'b1; end
      else a_pcnt <= a_pcnt - 1;
    end
    if (a_prep_start) begin
      tmp = to_mont(256'(a_prep_a1), 256'(a_prep_a3), 8);
      a_prep_result <= tmp[7:0];
      a_ppend <= 1'b1;
      a_pcnt  <= lat_p;
    end
    if (a_mpend) begin
      if (a_mcnt <= 1) begin a_mpend <= 1'b0; a_mont_done <= 1'b1; end
      else a_mcnt <= a_mcnt - 1;
    end
    if (a_mont_start) begin
      if (a_mpend) a_ovl <= a_ovl + 1;
      tmp = mont(256'(a_mont_a), 256'(a_mont_b), 256'(a_mont_n), 8);
      a_mont_result <= tmp[7:0];
      a_mpend <= 1'b1;
      a_mcnt  <= lat_m;
      a_log.push_back({256'(a_mont_a), 256'(a_mont_b)});
    end
  end

  always @(posedge clk) begin
    b_prep_done <= 1'b0;
    b_mont_done <= 1'b0;
    if (b_done) b_dcnt <= b_dcnt + 1;
    if (b_ppend) begin
      if (b_pcnt <= 1) begin b_ppend <= 1'b0; b_prep_done <= 1'b1; end
      else b_pcnt <= b_pcnt - 1;
    end
    if (b_prep_start) begin
      b_prep_result <= to_mont(b_prep_a1, b_prep_a3, 256);
      b_ppend <= 1'b1;
      b_pcnt  <= lat_p;
    end
    if (b_mpend) begin
      if (b_mcnt <= 1) begin b_mpend <= 1'b0; b_mont_done <= 1'b1; end
      else b_mcnt <= b_mcnt - 1;
    end
    if (b_mont_start) begin
      if (b_mpend) b_ovl <= b_ovl + 1;
      b_mont_result <= mont(b_mont_a, b_mont_b, b_mont_n, 256);
      b_mpend <= 1'b1;
      b_mcnt  <= lat_m;
      b_log.push_back({b_mont_a, b_mont_b});
    end
  end

  // Observation mux over the instance under test
  logic [255:0] o_m, o_a1, o_a3, o_mn;
  logic         o_done, o_busy, o_ps;
  assign o_m    = big ? b_m       : 256'(a_m);
  assign o_a1   = big ? b_prep_a1 : 256'(a_prep_a1);
  assign o_a3   = big ? b_prep_a3 : 256'(a_prep_a3);
  assign o_mn   = big ? b_mont_n  : 256'(a_mont_n);
  assign o_done = big ? b_done    : a_done;
  assign o_busy = big ? b_busy    : a_busy;
  assign o_ps   = big ? b_prep_start : a_prep_start;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One exponentiation on the selected instance, checked against the reference.
  task automatic run(input bit isbig, input logic [255:0] tn, input logic [255:0] te,
                     input logic [255:0] ty, input int lp, input int lm, input string tag,
                     input bit repulse, input bit chk_lat);
    int nb, it, muls, extra, exp_cyc, cyc, base, d0, o0, nlog;
    bit got, arm, pulsed;
    logic [255:0] p, acc, tm, gold;
    logic [511:0] exp_q[$];
    logic [511:0] ent;
    nb = isbig ? 256 : 8;
    got = 1'b0; arm = 1'b0; pulsed = 1'b0; cyc = 0;

    // reference: operand trace, result and latency from the algorithm's rules
    it    = EARLY ? bitlen(te) : nb;
    muls  = popcnt(te);
    extra = (EARLY && bitlen(te) < nb) ? 1 : 0;
    exp_cyc = 2 + lp + it * (3 + lm) + muls * (2 + lm) + extra;
    p   = mulmod(ty, 256'd1, tn);
    acc = 256'd1;
    for (int i = 0; i < it; i++) begin
      tm = to_mont(p, tn, nb);
      if (te[i]) exp_q.push_back({acc, tm});
      exp_q.push_back({tm, tm});
      if (te[i]) acc = mulmod(acc, p, tn);
      p = mulmod(p, p, tn);
    end
    gold = modexp(ty, te, tn, nb);

    @(negedge clk);
    big = isbig; lat_p = lp; lat_m = lm;
    base = isbig ? b_log.size() : a_log.size();
    d0   = isbig ? b_dcnt : a_dcnt;
    o0   = isbig ? b_ovl  : a_ovl;
    if (isbig) begin b_n = tn; b_e = te; b_y = ty; b_start = 1'b1; end
    else begin a_n = tn[7:0]; a_e = te[7:0]; a_y = ty[7:0]; a_start = 1'b1; end
    @(posedge clk); #1;
    a_start = 1'b0; b_start = 1'b0;
    chk({tag, "_busy_on"}, 256'(o_busy), 256'd1);
    chk({tag, "_prep_start"}, 256'(o_ps), 256'd1);

    while (!got && cyc < 20000) begin
      @(posedge clk); #1;
      cyc++;
      if (o_done) got = 1'b1;
      else if (repulse && !isbig) begin
        if (a_start) begin
          a_start = 1'b0; a_n = tn[7:0]; a_e = te[7:0]; a_y = ty[7:0];
        end else if (arm) begin
          a_start = 1'b1; a_n = 8'd77; a_e = 8'd200; a_y = 8'd9;
          arm = 1'b0; pulsed = 1'b1;
        end else if (!pulsed && a_mont_start) arm = 1'b1;
      end
    end
    a_start = 1'b0;

    chk({tag, "_done_seen"}, 256'(got), 256'd1);
    if (repulse) chk({tag, "_repulsed"}, 256'(pulsed), 256'd1);
    if (got) begin
      chk({tag, "_m"}, o_m, gold);
      chk({tag, "_m_trace"}, o_m, acc);
      chk({tag, "_prep_a1"}, o_a1, ty);
      chk({tag, "_prep_a3"}, o_a3, tn);
      chk({tag, "_mont_n"}, o_mn, tn);
      nlog = (isbig ? b_log.size() : a_log.size()) - base;
      chk({tag, "_nreq"}, 256'(nlog), 256'(exp_q.size()));
      for (int k = 0; k < exp_q.size() && k < nlog; k++) begin
        ent = isbig ? b_log[base + k] : a_log[base + k];
        chk({tag, "_opA"}, ent[511:256], exp_q[k][511:256]);
        chk({tag, "_opB"}, ent[255:0], exp_q[k][255:0]);
      end
      if (chk_lat) chk({tag, "_latency"}, 256'(cyc), 256'(exp_cyc));
    end
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_busy_off"}, 256'(o_busy), 256'd0);
    chk({tag, "_done_once"}, 256'((isbig ? b_dcnt : a_dcnt) - d0), 256'd1);
    chk({tag, "_no_overlap"}, 256'((isbig ? b_ovl : a_ovl) - o0), 256'd0);
    chk({tag, "_m_held"}, o_m, gold);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt, guard;
    logic [255:0] rn, re, ry;

    // reset values while rst is held
    repeat (2) @(negedge clk);
    chk("rst_m8", 256'(a_m), 256'd0);
    chk("rst_done8", 256'(a_done), 256'd0);
    chk("rst_busy8", 256'(a_busy), 256'd0);
    chk("rst_pstart8", 256'(a_prep_start), 256'd0);
    chk("rst_mstart8", 256'(a_mont_start), 256'd0);
    chk("rst_m256", b_m, 256'd0);
    chk("rst_busy256", 256'(b_busy), 256'd0);
    rst = 1'b0;

    // textbook example and the zero exponent
    run(1'b0, 256'd187, 256'd7, 256'd88, 3, 2, "t1", 1'b0, 1'b1);
    chk("t1_m11", 256'(a_m), 256'd11);
    run(1'b0, 256'd13, 256'd0, 256'd5, 2, 2, "t2", 1'b0, 1'b1);
    chk("t2_m1", 256'(a_m), 256'd1);

    // start re-pulsed while a multiply is outstanding
    run(1'b0, 256'd187, 256'd7, 256'd88, 2, 3, "t4", 1'b1, 1'b1);
    chk("t4_m11", 256'(a_m), 256'd11);

    // reset during the first squaring wait, then a fresh run
    @(negedge clk);
    big = 1'b0; lat_p = 10; lat_m = 6;
    a_n = 8'd187; a_e = 8'd7; a_y = 8'd88; a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    cnt = 0; guard = 0;
    while (cnt < 2 && guard < 2000) begin
      @(posedge clk); #1;
      guard++;
      if (a_mont_start) cnt++;
    end
    chk("t5_reach_sqr", 256'(cnt), 256'd2);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_m", 256'(a_m), 256'd0);
    chk("t5_rst_busy", 256'(a_busy), 256'd0);
    chk("t5_rst_done", 256'(a_done), 256'd0);
    chk("t5_rst_mstart", 256'(a_mont_start), 256'd0);
    @(negedge clk);
    rst = 1'b0;
    run(1'b0, 256'd187, 256'd7, 256'd88, 10, 6, "t5", 1'b0, 1'b0);
    chk("t5_m11", 256'(a_m), 256'd11);

    // short exponent: iteration count depends on the early-exit build option
    run(1'b0, 256'd187, 256'd3, 256'd88, 2, 2, "t6", 1'b0, 1'b1);

    // randomized operands and unit latencies
    for (int r = 0; r < 8; r++) begin
      rn = 256'($urandom_range(1, 127) * 2 + 1);
      ry = 256'($urandom_range(0, 32'(rn) - 1));
      re = 256'($urandom_range(0, 255));
      run(1'b0, rn, re, ry, int'($urandom_range(1, 5)), int'($urandom_range(1, 4)),
          "rnd", 1'b0, 1'b1);
    end

    // full-width run with the public exponent 65537
    run(1'b1,
        256'hE07122F2_A4D5C1B7_3F9E6D08_51C2B4A7_9D3E6F10_2B8C7A45_E1F09D36_0CCA73E1,
        256'd65537, 256'd192304, 2, 3, "t3", 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
